// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - immediate formats, opcodes and decode function; IMM_GEN_CSR_EN enables FMT_Z for CSR*I
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_R    = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Immediate is always built at 64 bits; callers keep the low XLEN bits.
    typedef struct packed {
        logic [63:0] imm;
        fmt_e        fmt;
        logic        illegal;
    } dec_t;

    function automatic dec_t imm_decode(input logic [31:0] instr, input logic is64);
        dec_t d;
        d.imm     = '0;
        d.fmt     = FMT_NONE;
        d.illegal = 1'b0;
        case (instr[6:0])
            OP_IMM: begin
                d.fmt = FMT_I;
                if (instr[13:12] == 2'b01)
                    d.imm = is64 ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
                else
                    d.imm = {{52{instr[31]}}, instr[31:20]};
            end
            OP_LOAD, OP_JALR: begin
                d.fmt = FMT_I;
                d.imm = {{52{instr[31]}}, instr[31:20]};
            end
            OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
                if (instr[14]) begin
                    d.fmt = FMT_Z;
                    d.imm = {59'b0, instr[19:15]};
                end else begin
                    d.fmt = FMT_I;
                    d.imm = {{52{instr[31]}}, instr[31:20]};
                end
`else
                d.fmt = FMT_I;
                d.imm = {{52{instr[31]}}, instr[31:20]};
`endif
            end
            OP_STORE: begin
                d.fmt = FMT_S;
                d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                d.fmt = FMT_B;
                d.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                d.fmt = FMT_U;
                d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            end
            OP_JAL: begin
                d.fmt = FMT_J;
                d.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_REG: d.fmt = FMT_R;
            // Every recognised opcode ends in 2'b11, so compressed encodings land here too.
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen_skid.sv
// rtl/imm_gen_skid.sv - generic 2-entry skid buffer (output reg + skid reg) with synchronous flush
module imm_gen_skid #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          r_out_valid;
    logic [DW-1:0] r_out_data;
    logic          r_skid_valid;
    logic [DW-1:0] r_skid_data;
    logic          w_in_fire;
    logic          w_out_free;

    assign in_ready   = ~r_skid_valid;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign w_in_fire  = in_valid && ~r_skid_valid;
    assign w_out_free = ~r_out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // Skid entry is older than anything on the input, so it drains first.
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out_data  <= in_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data  <= in_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate decode stage (decode + skid); IMM_GEN_CSR_EN adds FMT_Z decode
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int INSTRUCTION = 32,
    parameter int XLEN        = 32,
    parameter int TAG_W       = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTRUCTION-1:0] in_instr,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_imm,
    output logic [2:0]             out_fmt,
    output logic                   out_illegal,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int PW = XLEN + 3 + 1 + TAG_W;

    dec_t          w_dec;
    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_out_payload;
    logic          w_unused_imm;

    assign w_dec        = imm_decode(in_instr, XLEN == 64);
    assign w_unused_imm = ^w_dec.imm;
    assign w_in_payload = {w_dec.imm[XLEN-1:0], w_dec.fmt, w_dec.illegal, in_tag};

    imm_gen_skid #(
        .DW(PW)
    ) u_skid (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (w_in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (w_out_payload)
    );

    assign {out_imm, out_fmt, out_illegal, out_tag} = w_out_payload;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed bench for imm_gen_stage at XLEN=32 and XLEN=64
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_tag, out_imm, out_tag;
    logic [2:0]  out_fmt;

    logic        in64_valid, in64_ready, out64_valid, out64_ready, out64_illegal;
    logic [31:0] in64_instr, in64_tag, out64_tag;
    logic [63:0] out64_imm;
    logic [2:0]  out64_fmt;

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] tag_ctr = 32'h100;

    always #5 clk = ~clk;

    imm_gen_stage #(.INSTRUCTION(32), .XLEN(32), .TAG_W(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_stage #(.INSTRUCTION(32), .XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in64_valid), .in_ready(in64_ready), .in_instr(in64_instr), .in_tag(in64_tag),
        .out_valid(out64_valid), .out_ready(out64_ready), .out_imm(out64_imm),
        .out_fmt(out64_fmt), .out_illegal(out64_illegal), .out_tag(out64_tag)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    task automatic run_vec(input string nm, input logic [31:0] instr, input logic [31:0] eimm,
                           input logic [2:0] efmt, input logic eill);
        logic [31:0] t;
        t = tag_ctr;
        tag_ctr = tag_ctr + 32'd4;
        @(negedge clk);
        in_valid = 1'b1; in_instr = instr; in_tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, ".valid"}, {63'b0, out_valid}, 64'd1);
        chk({nm, ".imm"}, {32'b0, out_imm}, {32'b0, eimm});
        chk({nm, ".fmt"}, {61'b0, out_fmt}, {61'b0, efmt});
        chk({nm, ".ill"}, {63'b0, out_illegal}, {63'b0, eill});
        chk({nm, ".tag"}, {32'b0, out_tag}, {32'b0, t});
    endtask

    task automatic run_vec64(input string nm, input logic [31:0] instr, input logic [63:0] eimm,
                             input logic [2:0] efmt);
        @(negedge clk);
        in64_valid = 1'b1; in64_instr = instr; in64_tag = 32'hCAFE0000 | instr[15:0];
        @(posedge clk); #1;
        in64_valid = 1'b0;
        chk({nm, ".valid"}, {63'b0, out64_valid}, 64'd1);
        chk({nm, ".imm"}, out64_imm, eimm);
        chk({nm, ".fmt"}, {61'b0, out64_fmt}, {61'b0, efmt});
        chk({nm, ".tag"}, {32'b0, out64_tag}, {32'b0, 32'hCAFE0000 | instr[15:0]});
    endtask

    // Leaves A in the output register and B in the skid entry with out_ready low.
    task automatic fill_both(input logic [31:0] ta, input logic [31:0] tb);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00100093; in_tag = ta;
        @(negedge clk);
        in_instr = 32'h00200093; in_tag = tb;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        in64_valid = 1'b0; in64_instr = '0; in64_tag = '0; out64_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst.in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst.imm", {32'b0, out_imm}, 64'd0);
        chk("rst.fmt", {61'b0, out_fmt}, 64'd0);
        chk("rst.tag", {32'b0, out_tag}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_vec("addi",  32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
        run_vec("beq",   32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
        run_vec("lui",   32'h123450B7, 32'h12345000, 3'd4, 1'b0);
        run_vec("sw",    32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
        run_vec("jal",   32'h0080006F, 32'h00000008, 3'd5, 1'b0);
        run_vec("add",   32'h002081B3, 32'h00000000, 3'd7, 1'b0);
        run_vec("slli32", 32'h03F09093, 32'h0000001F, 3'd1, 1'b0);
        run_vec("zero",  32'h00000000, 32'h00000000, 3'd0, 1'b1);
        run_vec("rvc",   32'h00000090, 32'h00000000, 3'd0, 1'b1);
`ifdef IMM_GEN_CSR_EN
        run_vec("csrrwi", 32'h340FD073, 32'h0000001F, 3'd6, 1'b0);
`else
        run_vec("csrrwi", 32'h340FD073, 32'h00000340, 3'd1, 1'b0);
`endif
        run_vec("csrrw", 32'h34009073, 32'h00000340, 3'd1, 1'b0);

        run_vec64("addi64", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
        run_vec64("slli64", 32'h03F09093, 64'd63, 3'd1);
        run_vec64("beq64",  32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);

        // Backpressure: A held, B skidded, C stalls, then A,B,C drain back to back.
        @(posedge clk); #1;
        fill_both(32'hA, 32'hB);
        chk("stall.in_ready_b", {63'b0, in_ready}, 64'd0);
        chk("stall.tag_a0", {32'b0, out_tag}, 64'hA);
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h00300093; in_tag = 32'hC;
        @(posedge clk); #1;
        chk("stall.tag_a1", {32'b0, out_tag}, 64'hA);
        chk("stall.imm_a1", {32'b0, out_imm}, 64'd1);
        chk("stall.in_ready_c", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain.valid_b", {63'b0, out_valid}, 64'd1);
        chk("drain.tag_b", {32'b0, out_tag}, 64'hB);
        chk("drain.imm_b", {32'b0, out_imm}, 64'd2);
        chk("drain.in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("drain.valid_c", {63'b0, out_valid}, 64'd1);
        chk("drain.tag_c", {32'b0, out_tag}, 64'hC);
        chk("drain.imm_c", {32'b0, out_imm}, 64'd3);
        @(posedge clk); #1;
        chk("drain.empty", {63'b0, out_valid}, 64'd0);

        // Flush with both entries held; input offered the same cycle is dropped.
        fill_both(32'h11, 32'h12);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00400093; in_tag = 32'h13;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush.in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush.no_ghost", {63'b0, out_valid}, 64'd0);

        // Asynchronous reset while stalled.
        fill_both(32'h21, 32'h22);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("arst.out_valid", {63'b0, out_valid}, 64'd0);
        chk("arst.in_ready", {63'b0, in_ready}, 64'd1);
        chk("arst.imm", {32'b0, out_imm}, 64'd0);
        chk("arst.tag", {32'b0, out_tag}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        run_vec("post_rst", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
